// File: rtl/vadd_stream_engine.sv
// Multi-lane stream ALU: add/sub/signed-max/signed-min of every lane with a job constant, with job framing.
// Build option VADD_SATURATE_EN: add/sub saturate to the signed lane range instead of wrapping.
module vadd_stream_engine #(
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_ELEM_WIDTH  = 32,
    parameter int C_PIPE_STAGES = 2,
    parameter int C_LEN_WIDTH   = 32
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    ctrl_start,
    input  logic [1:0]              ctrl_mode,
    input  logic [C_ELEM_WIDTH-1:0] ctrl_constant,
    input  logic [C_LEN_WIDTH-1:0]  ctrl_num_beats,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_LEN_WIDTH-1:0]  stat_beats_out
);

    localparam int E     = C_ELEM_WIDTH;
    localparam int LANES = C_DATA_WIDTH / C_ELEM_WIDTH;

`ifdef VADD_SATURATE_EN
    localparam logic signed [E-1:0] SAT_MAX = {1'b0, {(E-1){1'b1}}};
    localparam logic signed [E-1:0] SAT_MIN = {1'b1, {(E-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [1:0]              mode;
    logic signed [E-1:0]     cnst;
    logic [C_LEN_WIDTH-1:0]  num_beats;
    logic [C_LEN_WIDTH-1:0]  in_cnt;
    logic [C_LEN_WIDTH-1:0]  out_cnt;
    logic                    adv;
    logic                    s_fire;
    logic                    m_fire;
    logic [C_DATA_WIDTH-1:0] op_data;
    logic [C_PIPE_STAGES-1:0] vld_p;
    logic [C_DATA_WIDTH-1:0] data_p [C_PIPE_STAGES];

    function automatic logic signed [E-1:0] add_sub(input logic signed [E-1:0] x,
                                                    input logic signed [E-1:0] c,
                                                    input logic sub);
`ifdef VADD_SATURATE_EN
        logic signed [E:0] s;
        s = sub ? ({x[E-1], x} - {c[E-1], c}) : ({x[E-1], x} + {c[E-1], c});
        // Sign bits disagree only when the true result left the E-bit signed range.
        if (s[E] == s[E-1])
            return s[E-1:0];
        return s[E] ? SAT_MIN : SAT_MAX;
`else
        return sub ? (x - c) : (x + c);
`endif
    endfunction

    function automatic logic [E-1:0] lane_op(input logic [1:0] m,
                                             input logic signed [E-1:0] x,
                                             input logic signed [E-1:0] c);
        logic [E-1:0] r;
        case (m)
            2'd0:    r = add_sub(x, c, 1'b0);
            2'd1:    r = add_sub(x, c, 1'b1);
            2'd2:    r = (x > c) ? x : c;
            default: r = (x < c) ? x : c;
        endcase
        return r;
    endfunction

    assign adv           = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == S_RUN) && adv && (in_cnt < num_beats);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        op_data = '0;
        for (int i = 0; i < LANES; i++)
            op_data[i*E +: E] = lane_op(mode, s_axis_tdata[i*E +: E], cnst);
    end

    // Stage 1 holds the computed lanes; later stages only register, all moving together on adv.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p[0] <= s_fire;
            for (int k = 1; k < C_PIPE_STAGES; k++)
                vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (adv) begin
            data_p[0] <= op_data;
            for (int k = 1; k < C_PIPE_STAGES; k++)
                data_p[k] <= data_p[k-1];
        end
    end

    // Data registers are not reset, so the output is gated by valid to read 0 out of reset.
    assign m_axis_tvalid  = vld_p[C_PIPE_STAGES-1];
    assign m_axis_tdata   = m_axis_tvalid ? data_p[C_PIPE_STAGES-1] : '0;
    assign m_axis_tlast   = m_axis_tvalid && (out_cnt == num_beats - 1'b1);
    assign stat_beats_out = out_cnt;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= S_IDLE;
            mode      <= '0;
            cnst      <= '0;
            num_beats <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            ctrl_busy <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            if (s_fire)
                in_cnt <= in_cnt + 1'b1;
            if (m_fire)
                out_cnt <= out_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        mode      <= ctrl_mode;
                        cnst      <= ctrl_constant;
                        num_beats <= ctrl_num_beats;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        ctrl_busy <= 1'b1;
                        if (ctrl_num_beats == '0) begin
                            state     <= S_DONE;
                            ctrl_done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (s_fire && (in_cnt + 1'b1 == num_beats))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (m_fire && (out_cnt + 1'b1 == num_beats)) begin
                        state     <= S_DONE;
                        ctrl_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ctrl_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_stream_engine.sv
// Bench for vadd_stream_engine: hand-derived vector table, scoreboarded stream jobs, stall and reset sequences.
`timescale 1ns/1ps
module tb_vadd_stream_engine;

    localparam int DW    = 512;
    localparam int EW    = 32;
    localparam int PS    = 2;
    localparam int LW    = 32;
    localparam int LANES = DW / EW;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] c;
        logic [31:0] x;
        logic [31:0] want;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } sb_t;

    logic          clk;
    logic          areset_n;
    logic          ctrl_start;
    logic [1:0]    ctrl_mode;
    logic [EW-1:0] ctrl_constant;
    logic [LW-1:0] ctrl_num_beats;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [LW-1:0] stat_beats_out;

    sb_t           sb[$];
    logic [DW-1:0] src[$];
    vec_t          tbl[12];
    int            n_vec;
    int            n_err;

    vadd_stream_engine #(
        .C_DATA_WIDTH (DW),
        .C_ELEM_WIDTH (EW),
        .C_PIPE_STAGES(PS),
        .C_LEN_WIDTH  (LW)
    ) dut (
        .aclk          (clk),
        .areset_n      (areset_n),
        .ctrl_start    (ctrl_start),
        .ctrl_mode     (ctrl_mode),
        .ctrl_constant (ctrl_constant),
        .ctrl_num_beats(ctrl_num_beats),
        .ctrl_busy     (ctrl_busy),
        .ctrl_done     (ctrl_done),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .stat_beats_out(stat_beats_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] model_lane(input logic [1:0] m, input logic [31:0] x, input logic [31:0] c);
        longint sx, sc, r;
        sx = longint'($signed(x));
        sc = longint'($signed(c));
        case (m)
            2'd0:    r = sx + sc;
            2'd1:    r = sx - sc;
            2'd2:    r = (sx > sc) ? sx : sc;
            default: r = (sx < sc) ? sx : sc;
        endcase
`ifdef VADD_SATURATE_EN
        if (m[1] == 1'b0) begin
            if (r > 64'sd2147483647)  r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
        end
`endif
        return r[31:0];
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [1:0] m, input logic [31:0] c, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*EW +: EW] = model_lane(m, b[i*EW +: EW], c);
        return r;
    endfunction

    // Runs one job from start to done pulse, feeding src[] and scoring every output handshake.
    task automatic run_job(input logic [1:0] mode, input logic [31:0] c, input int n,
                           input bit gaps, input bit rand_rdy, input bit use_tbl, input logic [31:0] tbl_want,
                           output int first_acc, output int first_out, output int last_out, output int done_cyc);
        int            sent, outs, cyc;
        bit            done_seen, prev_stall, fired;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        sb_t           e;
        sent = 0; outs = 0; cyc = 0;
        done_seen = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        first_acc = -1; first_out = -1; last_out = -1; done_cyc = -1;
        ctrl_mode = mode; ctrl_constant = c; ctrl_num_beats = n; ctrl_start = 1'b1;
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        ctrl_mode = ~mode; ctrl_constant = ~c; ctrl_num_beats = n + 3;
        while (!done_seen && cyc < 300 + 20 * n) begin
            fired = 0;
            if (!s_axis_tvalid) begin
                if (sent < n) begin
                    if (!gaps || $urandom_range(0, 2) != 0) begin
                        s_axis_tvalid = 1'b1;
                        s_axis_tdata  = src[sent];
                    end
                end else if (!gaps) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = {LANES{32'hDEADBEEF}};
                end
            end
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("busy_in_job", ctrl_busy, 1);
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, prev_data);
                chk("stall_last", m_axis_tlast, prev_last);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (prev_stall)
                chk("stall_s_tready", s_axis_tready, 0);
            if (!m_axis_tvalid)
                chk("tlast_no_valid", m_axis_tlast, 0);
            if (m_axis_tvalid && first_out < 0)
                first_out = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                outs++;
                last_out = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", m_axis_tdata, e.data);
                    chk("out_last", m_axis_tlast, e.last);
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                fired = 1;
                if (sent >= n) begin
                    chk("extra_accept", 1, 0);
                end else begin
                    if (first_acc < 0)
                        first_acc = cyc;
                    e.data = use_tbl ? {LANES{tbl_want}} : model_beat(mode, c, src[sent]);
                    e.last = (sent == n - 1);
                    sb.push_back(e);
                    sent++;
                end
            end else if (s_axis_tvalid && sent >= n) begin
                chk("extra_blocked", s_axis_tready, 0);
            end
            if (ctrl_done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
            if (fired)
                s_axis_tvalid = 1'b0;
            cyc++;
        end
        if (!done_seen)
            chk("done_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk("beats_sent", sent, n);
        chk("beats_out", outs, n);
        chk("sb_empty", sb.size(), 0);
        chk("stat_beats", stat_beats_out, n);
        @(negedge clk);
        chk("done_one_cycle", ctrl_done, 0);
        chk("busy_after", ctrl_busy, 0);
        sb.delete();
    endtask

    task automatic load_ramp(input int n);
        logic [DW-1:0] b;
        src.delete();
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < LANES; i++)
                b[i*EW +: EW] = i + 16 * k;
            src.push_back(b);
        end
    endtask

    initial begin
        int            fa, fo, lo, dc;
        logic [DW-1:0] b;
        logic [31:0]   rc;
        n_vec = 0; n_err = 0;

        tbl[0]  = '{2'd0, 32'd5,        32'd10,       32'd15};
        tbl[1]  = '{2'd1, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        tbl[4]  = '{2'd2, 32'hFFFFFFFF, 32'd3,        32'd3};
        tbl[5]  = '{2'd2, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        tbl[6]  = '{2'd3, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF};
        tbl[7]  = '{2'd3, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        tbl[10] = '{2'd2, 32'd0,        32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[11] = '{2'd1, 32'd3,        32'd10,       32'd7};
`ifdef VADD_SATURATE_EN
        tbl[2]  = '{2'd1, 32'd1,        32'h80000000, 32'h80000000};
        tbl[3]  = '{2'd0, 32'd1,        32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[8]  = '{2'd1, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
        tbl[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h80000000};
`else
        tbl[2]  = '{2'd1, 32'd1,        32'h80000000, 32'h7FFFFFFF};
        tbl[3]  = '{2'd0, 32'd1,        32'h7FFFFFFF, 32'h80000000};
        tbl[8]  = '{2'd1, 32'h7FFFFFFF, 32'h80000000, 32'h00000001};
        tbl[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h00000000};
`endif

        areset_n = 1'b0; ctrl_start = 1'b1; ctrl_mode = 2'd0; ctrl_constant = '0; ctrl_num_beats = 32'd4;
        s_axis_tvalid = 1'b1; s_axis_tdata = {LANES{32'h12345678}}; m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_stat", stat_beats_out, 0);
        ctrl_start = 1'b0; s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        areset_n = 1'b1;
        @(posedge clk); #1;

        // Basic add job: latency and done-pulse placement.
        load_ramp(4);
        run_job(2'd0, 32'd5, 4, 0, 0, 0, '0, fa, fo, lo, dc);
        chk("t1_latency", fo - fa, PS);
        chk("t1_done_delay", dc - lo, 1);

        foreach (tbl[v]) begin
            src.delete();
            src.push_back({LANES{tbl[v].x}});
            run_job(tbl[v].mode, tbl[v].c, 1, 0, 0, 1, tbl[v].want, fa, fo, lo, dc);
        end

        // Signed max/min with alternating extreme lanes.
        src.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < LANES; i++)
                b[i*EW +: EW] = (i % 2 == k) ? 32'h00000003 : 32'h80000000;
            src.push_back(b);
        end
        run_job(2'd2, 32'hFFFFFFFF, 2, 0, 0, 0, '0, fa, fo, lo, dc);
        run_job(2'd3, 32'hFFFFFFFF, 2, 0, 0, 0, '0, fa, fo, lo, dc);

        // Random data under input gaps and random output back-pressure.
        src.delete();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < LANES; i++)
                b[i*EW +: EW] = $urandom;
            src.push_back(b);
        end
        rc = $urandom;
        run_job(2'd1, rc, 16, 1, 1, 0, '0, fa, fo, lo, dc);
        run_job(2'd0, rc, 16, 1, 1, 0, '0, fa, fo, lo, dc);

        // Zero-length job: done in the cycle right after start is sampled, no output traffic.
        src.delete();
        run_job(2'd0, 32'd7, 0, 0, 0, 0, '0, fa, fo, lo, dc);
        chk("t6_done_cycle", dc, 0);
        chk("t6_no_valid", fo, -1);

        // Reset in the middle of a stalled job.
        ctrl_mode = 2'd0; ctrl_constant = 32'd1; ctrl_num_beats = 32'd8; ctrl_start = 1'b1; m_axis_tready = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = {LANES{32'h10}};
        repeat (4) @(posedge clk);
        #1;
        chk("t6_stat_before_rst", stat_beats_out != 0, 1);
        m_axis_tready = 1'b0;
        @(posedge clk); #3;
        chk("t6_stalled_valid", m_axis_tvalid, 1);
        areset_n = 1'b0;
        #1;
        chk("t6_rst_busy", ctrl_busy, 0);
        chk("t6_rst_done", ctrl_done, 0);
        chk("t6_rst_s_tready", s_axis_tready, 0);
        chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_m_tdata", m_axis_tdata, 0);
        chk("t6_rst_m_tlast", m_axis_tlast, 0);
        chk("t6_rst_stat", stat_beats_out, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_done_in_rst", ctrl_done, 0);
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        @(posedge clk); #1;
        areset_n = 1'b1;
        @(negedge clk);
        chk("t6_no_done_after_rst", ctrl_done, 0);
        @(posedge clk); #1;
        load_ramp(4);
        run_job(2'd0, 32'd5, 4, 0, 0, 0, '0, fa, fo, lo, dc);
        chk("t6_post_rst_latency", fo - fa, PS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
